// File: rtl/perf_pkg.sv
// Shared types and default sizing for the performance counter unit.
// Saturating counters are selected by defining PERF_SATURATE_EN.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_NUM_EVENTS  = 4;
  localparam int unsigned DEF_CNT_WIDTH   = 32;
  localparam int unsigned DEF_CYCLE_LIMIT = 64;

endpackage

// File: rtl/perf_counter.sv
// Single counter with clear and sticky overflow flag.
// PERF_SATURATE_EN defined: hold at all-ones on overflow; otherwise wrap to zero.
module perf_counter
  import perf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        ovf <= 1'b1;
`ifdef PERF_SATURATE_EN
        count <= count;
`else
        count <= '0;
`endif
      end else begin
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Cycle and event counters with run/pause/auto-stop control and a snapshot bank.
// Counter overflow behaviour is selected by PERF_SATURATE_EN (see perf_counter).
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS  = DEF_NUM_EVENTS,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned CYCLE_LIMIT = DEF_CYCLE_LIMIT
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic                              clear_i,
  input  logic [NUM_EVENTS-1:0]             event_i,
  input  logic                              snap_req_i,
  input  logic [$clog2(NUM_EVENTS+1)-1:0]   rd_sel_i,
  output logic [CNT_WIDTH-1:0]              rd_data_o,
  output logic                              snap_valid_o,
  output logic [CNT_WIDTH-1:0]              cycle_o,
  output logic [NUM_EVENTS:0]               ovf_o,
  output logic                              done_o
);

  localparam int unsigned NUM_CNT  = NUM_EVENTS + 1;
  localparam int unsigned SEL_W    = $clog2(NUM_EVENTS + 1);
  localparam bit          LIMIT_EN = (CYCLE_LIMIT > 0);
  localparam logic [CNT_WIDTH-1:0] LIMIT_LAST =
    CNT_WIDTH'((CYCLE_LIMIT > 0) ? (CYCLE_LIMIT - 1) : 0);

  state_t               state;
  state_t               state_nxt;
  logic [NUM_CNT-1:0]   inc;
  logic [CNT_WIDTH-1:0] live   [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow [NUM_CNT];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Auto-stop wins over a pause requested on the same final cycle.
  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) state_nxt = RUN;
        RUN: begin
          if (LIMIT_EN && (live[0] == LIMIT_LAST)) state_nxt = DONE;
          else if (!start_i)                       state_nxt = IDLE;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    inc    = '0;
    done_o = 1'b0;
    case (state)
      RUN:     inc    = {event_i, 1'b1};
      DONE:    done_o = 1'b1;
      default: inc    = '0;
    endcase
  end

  // Index 0 is the cycle counter, index k+1 is event channel k.
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (clear_i),
      .inc   (inc[i]),
      .count (live[i]),
      .ovf   (ovf_o[i])
    );
  end

  assign cycle_o = live[0];

  // Snapshot takes the pre-edge live values; clear overrides a same-cycle request.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
      snap_valid_o <= 1'b0;
    end else if (snap_req_i) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
      snap_valid_o <= 1'b1;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_data_o = shadow[i];
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit: directed scenarios plus random traffic
// against a behavioural model; a second instance runs with no cycle limit.
module tb_perf_counter_unit;

  localparam int NE   = 4;
  localparam int CW   = 8;
  localparam int LIM  = 64;
  localparam int MAXV = (1 << CW) - 1;
`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst, start, clr, snap;
  logic [NE-1:0] ev;
  logic [2:0]    rd_sel;
  logic [CW-1:0] rd_data, cycle;
  logic          valid, done;
  logic [NE:0]   ovf;

  logic          z_start, z_clr, z_snap;
  logic [NE-1:0] z_ev;
  logic [2:0]    z_sel;
  logic [CW-1:0] z_rd, z_cycle;
  logic          z_valid, z_done;
  logic [NE:0]   z_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt [NE+1];
  bit m_ovf [NE+1];
  int m_sh  [NE+1];
  bit m_valid;
  int m_mode;

  always #10 clk = ~clk;

  perf_counter_unit #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .CYCLE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clr), .event_i(ev),
    .snap_req_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
    .snap_valid_o(valid), .cycle_o(cycle), .ovf_o(ovf), .done_o(done)
  );

  perf_counter_unit #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .CYCLE_LIMIT(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(z_start), .clear_i(z_clr), .event_i(z_ev),
    .snap_req_i(z_snap), .rd_sel_i(z_sel), .rd_data_o(z_rd),
    .snap_valid_o(z_valid), .cycle_o(z_cycle), .ovf_o(z_ovf), .done_o(z_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bump(input int i);
    if (m_cnt[i] == MAXV) begin
      m_ovf[i] = 1'b1;
      if (!SAT) m_cnt[i] = 0;
    end else begin
      m_cnt[i]++;
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs held before the edge.
  task automatic model_step();
    if (rst || clr) begin
      m_mode  = M_IDLE;
      m_valid = 1'b0;
      for (int i = 0; i <= NE; i++) begin
        m_cnt[i] = 0; m_ovf[i] = 1'b0; m_sh[i] = 0;
      end
      return;
    end
    if (snap) begin
      for (int i = 0; i <= NE; i++) m_sh[i] = m_cnt[i];
      m_valid = 1'b1;
    end
    case (m_mode)
      M_IDLE: if (start) m_mode = M_RUN;
      M_RUN: begin
        bump(0);
        for (int k = 0; k < NE; k++) if (ev[k]) bump(k + 1);
        if (LIM > 0 && m_cnt[0] == LIM) m_mode = M_DONE;
        else if (!start)                m_mode = M_IDLE;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    logic [NE:0]   eo;
    logic [63:0]   exp;
    for (int i = 0; i <= NE; i++) eo[i] = m_ovf[i];
    chk("cycle", 64'(cycle), 64'(m_cnt[0]));
    chk("done", 64'(done), 64'(m_mode == M_DONE));
    chk("ovf", 64'(ovf), 64'(eo));
    chk("snap_valid", 64'(valid), 64'(m_valid));
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      exp = 64'd0;
      if (s <= NE) exp = 64'(m_sh[s]);
      chk($sformatf("rd%0d", s), 64'(rd_data), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    int n;
    logic [CW-1:0] z_exp;
    rst = 1'b1; start = 1'b0; clr = 1'b0; snap = 1'b0; ev = '0; rd_sel = '0;
    z_start = 1'b0; z_clr = 1'b0; z_snap = 1'b0; z_ev = '0; z_sel = '0;
    tick(); tick();
    chk("reset_cycle", 64'(cycle), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Full run to the cycle limit with two event patterns
    start = 1'b1;
    for (int i = 0; i < 70; i++) begin
      ev = 4'b0001;
      if (i % 4 == 0) ev[1] = 1'b1;
      tick();
    end
    snap = 1'b1; tick(); snap = 1'b0; ev = '0;
    chk("limit_done", 64'(done), 64'd1);
    chk("limit_cycle", 64'(cycle), 64'd64);
    rd_sel = 3'd1; #1; chk("limit_ch0", 64'(rd_data), 64'd64);
    rd_sel = 3'd2; #1; chk("limit_ch1", 64'(rd_data), 64'd16);

    // Clear with snapshot request while in DONE, start still high
    clr = 1'b1; snap = 1'b1; tick();
    clr = 1'b0; snap = 1'b0; start = 1'b0;
    chk("clr_cycle", 64'(cycle), 64'd0);
    chk("clr_valid", 64'(valid), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    tick();
    chk("clr_idle", 64'(cycle), 64'd0);

    // Pause and resume
    start = 1'b1; repeat (10) tick();
    start = 1'b0; repeat (3) tick();
    chk("pause_frozen", 64'(cycle), 64'd10);
    repeat (2) tick();
    start = 1'b1; repeat (10) tick();
    start = 1'b0; tick();
    chk("pause_total", 64'(cycle), 64'd20);

    // Snapshot excludes the capture cycle's increments
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; ev = 4'b0001;
    for (int k = 0; k < 100 && cycle != 8'd30; k++) tick();
    chk("reach30", 64'(cycle), 64'd30);
    snap = 1'b1; tick(); snap = 1'b0;
    chk("snap_live", 64'(cycle), 64'd31);
    chk("snap_valid1", 64'(valid), 64'd1);
    rd_sel = 3'd0; #1; chk("snap_cyc", 64'(rd_data), 64'd30);
    rd_sel = 3'd1; #1; chk("snap_ch0", 64'(rd_data), 64'd30);
    snap = 1'b1; tick(); snap = 1'b0;
    rd_sel = 3'd1; #1; chk("live_ch0", 64'(rd_data), 64'd31);

    // Reset mid-run restarts counting
    for (int k = 0; k < 100 && cycle != 8'd40; k++) tick();
    chk("reach40", 64'(cycle), 64'd40);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid", 64'(cycle), 64'd0);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("rst_latency", 64'(n), 64'd65);
    chk("rst_cycle", 64'(cycle), 64'd64);

    // Random traffic
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 99) < 85);
      ev    = 4'($urandom);
      snap  = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0; clr = 1'b0; start = 1'b0; ev = '0; snap = 1'b0;

    // Unlimited instance: 300 RUN cycles with channel 2 always active
    z_clr = 1'b1; tick(); z_clr = 1'b0;
    z_start = 1'b1; z_ev = 4'b0100;
    repeat (300) tick();
    z_start = 1'b0; tick();
    z_exp = SAT ? 8'd255 : 8'd44;
    chk("nolim_cycle", 64'(z_cycle), 64'(z_exp));
    chk("nolim_ovf", 64'(z_ovf), 64'h09);
    chk("nolim_done", 64'(z_done), 64'd0);
    z_ev = '0; z_snap = 1'b1; tick(); z_snap = 1'b0;
    chk("nolim_valid", 64'(z_valid), 64'd1);
    z_sel = 3'd3; #1; chk("nolim_ch2", 64'(z_rd), 64'(z_exp));
    z_sel = 3'd1; #1; chk("nolim_ch0", 64'(z_rd), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 Parameter NUM_EVENTS, default 4: number of independent event channels (1..16).
REQ-002 Parameter CNT_WIDTH, default 32: width of the cycle counter and of every event counter (8..64).
REQ-003 Parameter CYCLE_LIMIT, default 64: RUN cycles before automatic stop; 0 means no limit.
REQ-004 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 start_i  input  1  counting enable; high requests RUN.
REQ-007 clear_i  input  1  synchronous clear of all counters, flags and snapshot; return to IDLE.
REQ-008 event_i  input  NUM_EVENTS  per-channel event strobes (e.g. stall, flush), one count per high cycle.
REQ-009 snap_req_i  input  1  capture all live counters into the shadow bank.
REQ-010 rd_sel_i  input  clog2(NUM_EVENTS+1)  shadow read index; 0 = cycle count, k = event channel k-1.
REQ-011 rd_data_o  output  CNT_WIDTH  combinational shadow value at rd_sel_i; 0 for out-of-range index.
REQ-012 snap_valid_o  output  1  shadow bank holds a valid capture.
REQ-013 cycle_o  output  CNT_WIDTH  live RUN-cycle count.
REQ-014 ovf_o  output  NUM_EVENTS+1  sticky overflow flags; bit 0 cycle counter, bit k channel k-1.
REQ-015 done_o  output  1  high while in DONE.

Function
REQ-016 States IDLE, RUN, DONE; IDLE->RUN when start_i=1; RUN->IDLE when start_i=0 (pause, counts held); DONE->IDLE only on clear_i.
REQ-017 In RUN, cycle_o increments by 1 every cycle; event counter k increments in the same cycle iff event_i[k]=1.
REQ-018 In IDLE and DONE, no counter changes; event_i is ignored.
REQ-019 With CYCLE_LIMIT>0, the RUN edge at which cycle_o goes from CYCLE_LIMIT-1 to CYCLE_LIMIT moves to DONE; events in that cycle are counted; done_o rises that same edge.
REQ-020 Counter at all-ones receiving an increment wraps to 0 and sets its ovf_o bit; ovf_o bits stay set until clear_i or reset.
REQ-021 snap_req_i=1 at an edge loads the shadow bank with the pre-edge live values (increments of that cycle excluded); snap_valid_o=1 from that edge.
REQ-022 A later snap_req_i overwrites the shadow bank; snap_valid_o stays 1.
REQ-023 Priority per edge: rst_i > clear_i > snap_req_i/counting; clear_i with snap_req_i zeroes the bank and leaves snap_valid_o=0.
REQ-024 clear_i from any state: all counters, shadow bank, ovf_o, snap_valid_o to 0; state IDLE, regardless of start_i that cycle.

Reset
REQ-025 rst_i=1 at an edge: state IDLE; cycle_o=0, all event counters 0, shadow bank 0, ovf_o=0, snap_valid_o=0, done_o=0.
REQ-026 Reset asserted mid-RUN or in DONE discards all counts; first RUN cycle after release counts from 0.

Configuration
REQ-027 Macro PERF_SATURATE_EN defined: counters at all-ones hold at all-ones on further increments and set their ovf_o bit.
REQ-028 Macro PERF_SATURATE_EN undefined: wrap-around behaviour of REQ-020.

Structure
REQ-029 Package perf_pkg holds the state enum (IDLE, RUN, DONE) and default constants for NUM_EVENTS, CNT_WIDTH, CYCLE_LIMIT.
REQ-030 One sub-module perf_counter: single CNT_WIDTH counter with inc, clear, sticky overflow and the PERF_SATURATE_EN option; instantiated NUM_EVENTS+1 times.

Verification (NUM_EVENTS=4, CNT_WIDTH=8, CYCLE_LIMIT=64 unless noted)
REQ-031 Reset, start_i=1, event_i[0] high every cycle, event_i[1] every 4th cycle -> after 64 RUN cycles: done_o=1, cycle_o=64, ch0=64, ch1=16, further events not counted.
REQ-032 start_i high 10 cycles, low 5, high 10 -> cycle_o=20, state IDLE during gap, counts frozen.
REQ-033 CYCLE_LIMIT=0, event_i[2] constant for 300 cycles -> ch2=44 with ovf_o[3]=1 (wrap); with PERF_SATURATE_EN ch2=255, ovf_o[3]=1.
REQ-034 snap_req_i at cycle_o=30 with event_i[0] high -> rd_sel_i=0 gives 30, rd_sel_i=1 gives 30 while live ch0=31; snap_valid_o=1.
REQ-035 clear_i together with snap_req_i in DONE -> next cycle all outputs 0, snap_valid_o=0, state IDLE.
REQ-036 rst_i pulse at cycle_o=40 with start_i held -> counts restart from 0, done_o after 64 further RUN cycles.
